// File: rtl/gmii_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// gmii_rx_frame_parser
//
// Receive framing stage on a GMII receive bus. It finds the preamble and SFD,
// strips them, holds back the trailing 4-byte FCS, and forwards payload bytes
// as a valid-qualified stream. Every accepted frame ends with exactly one
// commit or drop pulse, which carries the payload byte count and drop reason.
//
// Ports
//   clk_mac             : MAC clock, the only clock
//   rst                 : synchronous active-high reset
//   gmii_rx_bus         : {dvalid, en, er, data[7:0]}; sampled only when dvalid=1
//   rx_frame_start      : one-cycle pulse, the cycle after the SFD is sampled
//   rx_frame_data_valid : payload byte present on rx_frame_data
//   rx_frame_data       : payload byte (the FCS never appears here)
//   rx_frame_commit     : one-cycle pulse, frame good
//   rx_frame_drop       : one-cycle pulse, frame bad
//   rx_frame_bytes      : payload bytes emitted; valid with commit/drop
//   rx_drop_reason      : {crc, giant, runt, er}; valid with drop
// ---------------------------------------------------------------------------
package gmii_rx_frame_parser_pkg;
    typedef struct packed {
        logic       dvalid;
        logic       en;
        logic       er;
        logic [7:0] data;
    } GmiiBus;
endpackage

module gmii_rx_frame_parser
    import gmii_rx_frame_parser_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1518,
    parameter int MIN_FRAME_LEN = 64,
    parameter bit CHECK_CRC     = 1'b1
) (
    input  logic        clk_mac,
    input  logic        rst,
    input  GmiiBus      gmii_rx_bus,
    output logic        rx_frame_start,
    output logic        rx_frame_data_valid,
    output logic [7:0]  rx_frame_data,
    output logic        rx_frame_commit,
    output logic        rx_frame_drop,
    output logic [10:0] rx_frame_bytes,
    output logic [3:0]  rx_drop_reason
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DROP} state_t;

    localparam int               CNT_W       = 16;
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_FRAME_LEN);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_FRAME_LEN);
    localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    // A giant frame has emitted exactly MAX_FRAME_LEN-4 payload bytes.
    localparam int               GIANT_INT   = (MAX_FRAME_LEN - 4 > 2047) ? 2047 : MAX_FRAME_LEN - 4;
    localparam logic [10:0]      GIANT_BYTES = 11'(GIANT_INT);

    state_t           state_reg;
    logic [4:0]       pre_cnt_reg;
    logic [CNT_W-1:0] byte_cnt_reg;
    logic [31:0]      crc_reg;
    logic             er_flag_reg;
    logic [7:0]       pipe_reg [4];

    logic             start_reg;
    logic             data_valid_reg;
    logic [7:0]       data_reg;
    logic             commit_reg;
    logic             drop_reg;
    logic [10:0]      bytes_reg;
    logic [3:0]       reason_reg;

    // Byte-wide CRC update, one reflected bit step per data bit (LSB first).
    logic [31:0] crc_stage [9];
    logic [31:0] crc_next;

    assign crc_stage[0] = crc_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_crc_bit
            assign crc_stage[gi+1] = (crc_stage[gi][0] ^ gmii_rx_bus.data[gi])
                                   ? ((crc_stage[gi] >> 1) ^ CRC_POLY)
                                   : (crc_stage[gi] >> 1);
        end
    endgenerate

    assign crc_next = crc_stage[8];

    // Holdback pipe: newest byte enters slot 0, slot 3 is the oldest and is
    // the one released once four younger bytes have arrived behind it.
    logic [7:0] pipe_shift [4];

    assign pipe_shift[0] = gmii_rx_bus.data;

    generate
        for (gi = 1; gi < 4; gi++) begin : g_pipe
            assign pipe_shift[gi] = pipe_reg[gi-1];
        end
    endgenerate

    // End-of-frame bookkeeping, evaluated against the counters before the
    // en=0 sample updates anything.
    logic [CNT_W-1:0] payload_cnt;
    logic [10:0]      payload_bytes;
    logic             runt_flag;
    logic             crc_flag;

    always_comb begin
        payload_cnt   = (byte_cnt_reg > CNT_W'(4)) ? (byte_cnt_reg - CNT_W'(4)) : '0;
        payload_bytes = (payload_cnt > CNT_W'(2047)) ? 11'h7FF : payload_cnt[10:0];
        runt_flag     = (byte_cnt_reg < MIN_CNT);
        crc_flag      = CHECK_CRC && (crc_reg != CRC_RESIDUE);
    end

    always_ff @(posedge clk_mac) begin
        if (rst) begin
            state_reg      <= IDLE;
            pre_cnt_reg    <= '0;
            byte_cnt_reg   <= '0;
            crc_reg        <= '0;
            er_flag_reg    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pipe_reg[i] <= '0;
            end
            start_reg      <= 1'b0;
            data_valid_reg <= 1'b0;
            data_reg       <= '0;
            commit_reg     <= 1'b0;
            drop_reg       <= 1'b0;
            bytes_reg      <= '0;
            reason_reg     <= '0;
        end else begin
            // Pulses last one cycle unless re-armed below.
            start_reg      <= 1'b0;
            data_valid_reg <= 1'b0;
            commit_reg     <= 1'b0;
            drop_reg       <= 1'b0;

            if (gmii_rx_bus.dvalid) begin
                case (state_reg)
                    IDLE: begin
                        if (gmii_rx_bus.en) begin
                            if (gmii_rx_bus.data == 8'h55) begin
                                state_reg   <= PREAMBLE;
                                pre_cnt_reg <= 5'd1;
                            end else begin
                                // Mid-frame join (e.g. after reset): skip the tail.
                                state_reg <= DROP;
                            end
                        end
                    end

                    PREAMBLE: begin
                        if (!gmii_rx_bus.en) begin
                            state_reg <= IDLE;
                        end else if (gmii_rx_bus.er) begin
                            state_reg <= DROP;
                        end else if (gmii_rx_bus.data == 8'h55) begin
                            if (pre_cnt_reg == 5'd15) begin
                                state_reg <= DROP;
                            end else begin
                                pre_cnt_reg <= pre_cnt_reg + 5'd1;
                            end
                        end else if (gmii_rx_bus.data == 8'hD5) begin
                            state_reg    <= FRAME;
                            start_reg    <= 1'b1;
                            crc_reg      <= 32'hFFFFFFFF;
                            byte_cnt_reg <= '0;
                            er_flag_reg  <= 1'b0;
                            bytes_reg    <= '0;
                            reason_reg   <= '0;
                        end else begin
                            state_reg <= DROP;
                        end
                    end

                    FRAME: begin
                        if (!gmii_rx_bus.en) begin
                            // Whatever sits in the pipe is the FCS; it is never emitted.
                            state_reg  <= IDLE;
                            bytes_reg  <= payload_bytes;
                            reason_reg <= {crc_flag, 1'b0, runt_flag, er_flag_reg};
                            if (crc_flag || runt_flag || er_flag_reg) begin
                                drop_reg <= 1'b1;
                            end else begin
                                commit_reg <= 1'b1;
                            end
                        end else if (byte_cnt_reg == MAX_CNT) begin
                            // One byte past the limit: stop emitting and end the frame now.
                            state_reg  <= DROP;
                            drop_reg   <= 1'b1;
                            bytes_reg  <= GIANT_BYTES;
                            reason_reg <= 4'b0100;
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                pipe_reg[i] <= pipe_shift[i];
                            end
                            byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                            crc_reg      <= crc_next;
                            er_flag_reg  <= er_flag_reg | gmii_rx_bus.er;
                            if (byte_cnt_reg >= CNT_W'(4)) begin
                                data_valid_reg <= 1'b1;
                                data_reg       <= pipe_reg[3];
                            end
                        end
                    end

                    DROP: begin
                        if (!gmii_rx_bus.en) begin
                            state_reg <= IDLE;
                        end
                    end

                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign rx_frame_start      = start_reg;
    assign rx_frame_data_valid = data_valid_reg;
    assign rx_frame_data       = data_reg;
    assign rx_frame_commit     = commit_reg;
    assign rx_frame_drop       = drop_reg;
    assign rx_frame_bytes      = bytes_reg;
    assign rx_drop_reason      = reason_reg;

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// Bench for gmii_rx_frame_parser. Two instances: dut_a checks the FCS,
// dut_b ignores it. Stimulus tasks push expected events (start, data beats,
// commit/drop) into a per-instance queue; a negedge monitor pops and compares
// whenever an instance presents an event.
// ---------------------------------------------------------------------------
module tb_gmii_rx_frame_parser;
    import gmii_rx_frame_parser_pkg::*;

    logic   clk_mac = 1'b0;
    logic   rst;
    GmiiBus bus_a;
    GmiiBus bus_b;

    always #4 clk_mac = ~clk_mac;

    logic        a_start, a_valid, a_commit, a_drop;
    logic [7:0]  a_data;
    logic [10:0] a_bytes;
    logic [3:0]  a_reason;
    logic        b_start, b_valid, b_commit, b_drop;
    logic [7:0]  b_data;
    logic [10:0] b_bytes;
    logic [3:0]  b_reason;

    gmii_rx_frame_parser #(.MAX_FRAME_LEN(1518), .MIN_FRAME_LEN(64), .CHECK_CRC(1'b1)) dut_a (
        .clk_mac(clk_mac), .rst(rst), .gmii_rx_bus(bus_a),
        .rx_frame_start(a_start), .rx_frame_data_valid(a_valid), .rx_frame_data(a_data),
        .rx_frame_commit(a_commit), .rx_frame_drop(a_drop),
        .rx_frame_bytes(a_bytes), .rx_drop_reason(a_reason)
    );

    gmii_rx_frame_parser #(.MAX_FRAME_LEN(1518), .MIN_FRAME_LEN(64), .CHECK_CRC(1'b0)) dut_b (
        .clk_mac(clk_mac), .rst(rst), .gmii_rx_bus(bus_b),
        .rx_frame_start(b_start), .rx_frame_data_valid(b_valid), .rx_frame_data(b_data),
        .rx_frame_commit(b_commit), .rx_frame_drop(b_drop),
        .rx_frame_bytes(b_bytes), .rx_drop_reason(b_reason)
    );

    // kind: 0 start, 1 data beat, 2 commit, 3 drop
    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic [10:0] bytes;
        logic [3:0]  reason;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  mon_en  = 1'b0;
    bit  timing_chk = 1'b1;
    bit  slow    = 1'b0;
    int  start_cyc [2];
    int  last_cyc  [2];
    int  nbeats    [2];

    logic [7:0] pay [0:1599];
    int         plen;

    always @(posedge clk_mac) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h required 0x%0h (cycle %0d)", name, id, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input int id);
        n_tests++;
        n_fail++;
        $display("FAIL %s dut%0d: got an output event, required none (cycle %0d)", name, id, cyc);
    endtask

    task automatic pop_exp(input int id, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '{kind: -1, data: 8'h0, bytes: 11'h0, reason: 4'h0};
        if (id == 0) begin
            if (q_a.size() == 0) ok = 1'b0;
            else e = q_a.pop_front();
        end else begin
            if (q_b.size() == 0) ok = 1'b0;
            else e = q_b.pop_front();
        end
    endtask

    task automatic push_exp(input int id, input exp_t e);
        if (id == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int id, input logic st, input logic v, input logic [7:0] d,
                       input logic cm, input logic dr, input logic [10:0] by, input logic [3:0] rs);
        exp_t e;
        bit   ok;
        if (v && (cm || dr)) fail_evt("beat_with_end", id);
        if (st) begin
            pop_exp(id, e, ok);
            if (!ok) fail_evt("unexpected_start", id);
            else chk("start_kind", id, 0, e.kind);
            start_cyc[id] = cyc;
            nbeats[id]    = 0;
        end
        if (v) begin
            pop_exp(id, e, ok);
            if (!ok) fail_evt("unexpected_beat", id);
            else begin
                chk("beat_kind", id, 1, e.kind);
                chk("beat_data", id, {24'h0, d}, {24'h0, e.data});
                if (timing_chk && nbeats[id] == 0)
                    chk("first_beat_latency", id, cyc - start_cyc[id], 5);
            end
            last_cyc[id] = cyc;
            nbeats[id]++;
        end
        if (cm || dr) begin
            pop_exp(id, e, ok);
            if (!ok) fail_evt("unexpected_end", id);
            else begin
                chk("end_kind", id, (cm && dr) ? 4 : (cm ? 2 : 3), e.kind);
                chk("end_bytes", id, {21'h0, by}, {21'h0, e.bytes});
                if (e.kind == 3) chk("drop_reason", id, {28'h0, rs}, {28'h0, e.reason});
                if (timing_chk && nbeats[id] > 0)
                    chk("end_latency", id, cyc - last_cyc[id], 1);
            end
        end
    endtask

    always @(negedge clk_mac) begin
        if (mon_en) begin
            mon(0, a_start, a_valid, a_data, a_commit, a_drop, a_bytes, a_reason);
            mon(1, b_start, b_valid, b_data, b_commit, b_drop, b_bytes, b_reason);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++)
            r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic make_payload(input int n, input int seed);
        for (int i = 0; i < n; i++) pay[i] = 8'((i * seed + 17) ^ (i >> 3));
        plen = n;
    endtask

    task automatic append_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) c = crc_byte(c, pay[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) pay[plen + k] = c[8*k +: 8];
        plen += 4;
    endtask

    task automatic append_zero_fcs();
        for (int k = 0; k < 4; k++) pay[plen + k] = 8'h00;
        plen += 4;
    endtask

    task automatic expect_frame(input int id, input int beats, input int end_kind,
                                input logic [10:0] bytes, input logic [3:0] reason);
        exp_t e;
        e = '{kind: 0, data: 8'h0, bytes: 11'h0, reason: 4'h0};
        push_exp(id, e);
        for (int i = 0; i < beats; i++) begin
            e.kind = 1;
            e.data = pay[i];
            push_exp(id, e);
        end
        e = '{kind: end_kind, data: 8'h0, bytes: bytes, reason: reason};
        push_exp(id, e);
    endtask

    task automatic set_bus(input int id, input logic dv, input logic en, input logic er, input logic [7:0] d);
        GmiiBus v;
        v.dvalid = dv;
        v.en     = en;
        v.er     = er;
        v.data   = d;
        if (id == 0) bus_a = v;
        else bus_b = v;
    endtask

    // One sampled bus cycle; in slow mode it is preceded by nine unsampled
    // cycles carrying junk that must be ignored.
    task automatic send_cycle(input int id, input logic en, input logic er, input logic [7:0] d);
        if (slow) begin
            for (int k = 0; k < 9; k++) begin
                @(posedge clk_mac); #1;
                set_bus(id, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
        end
        @(posedge clk_mac); #1;
        set_bus(id, 1'b1, en, er, d);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_start"},  0, {31'h0, a_start},  0);
        chk({name, "_valid"},  0, {31'h0, a_valid},  0);
        chk({name, "_data"},   0, {24'h0, a_data},   0);
        chk({name, "_commit"}, 0, {31'h0, a_commit}, 0);
        chk({name, "_drop"},   0, {31'h0, a_drop},   0);
        chk({name, "_bytes"},  0, {21'h0, a_bytes},  0);
        chk({name, "_reason"}, 0, {28'h0, a_reason}, 0);
        chk({name, "_start"},  1, {31'h0, b_start},  0);
        chk({name, "_valid"},  1, {31'h0, b_valid},  0);
        chk({name, "_commit"}, 1, {31'h0, b_commit}, 0);
        chk({name, "_drop"},   1, {31'h0, b_drop},   0);
        chk({name, "_bytes"},  1, {21'h0, b_bytes},  0);
        chk({name, "_reason"}, 1, {28'h0, b_reason}, 0);
    endtask

    // Preamble, optional SFD, then pay[0..plen-1] with en=1, then one en=0 sample.
    task automatic drive_frame(input int id, input int npre, input bit sfd, input int er_idx, input int rst_idx);
        for (int i = 0; i < npre; i++) send_cycle(id, 1'b1, 1'b0, 8'h55);
        if (sfd) send_cycle(id, 1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < plen; i++) begin
            send_cycle(id, 1'b1, (i == er_idx), pay[i]);
            if (i == rst_idx) begin
                rst = 1'b1;
                @(posedge clk_mac); #1;
                rst = 1'b0;
                if (id == 0) q_a.delete();
                else q_b.delete();
                check_zero("mid_frame_reset");
            end
        end
        send_cycle(id, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && k < 400) begin
            @(posedge clk_mac);
            k++;
        end
        n_tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d/%0d expected events pending, required 0", name, q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
        repeat (4) @(posedge clk_mac);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        set_bus(0, 1'b1, 1'b0, 1'b0, 8'h00);
        set_bus(1, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (4) @(posedge clk_mac);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk_mac); #1;
        mon_en = 1'b1;

        // Zero-FCS frame on the non-checking instance
        make_payload(110, 3); append_zero_fcs();
        expect_frame(1, 110, 2, 11'd110, 4'b0000);
        drive_frame(1, 8, 1'b1, -1, -1);
        wait_drain("zero_fcs");

        // Good FCS, exactly minimum length (60 + 4)
        make_payload(60, 5); append_fcs();
        expect_frame(0, 60, 2, 11'd60, 4'b0000);
        drive_frame(0, 7, 1'b1, -1, -1);
        wait_drain("crc_good");

        // Same frame, payload byte 10 bit0 flipped
        pay[10][0] = ~pay[10][0];
        expect_frame(0, 60, 3, 11'd60, 4'b1000);
        drive_frame(0, 7, 1'b1, -1, -1);
        wait_drain("crc_bad");

        // Runts
        make_payload(36, 7); append_fcs();
        expect_frame(0, 36, 3, 11'd36, 4'b0010);
        drive_frame(0, 7, 1'b1, -1, -1);
        wait_drain("runt36");
        make_payload(59, 9); append_fcs();
        expect_frame(0, 59, 3, 11'd59, 4'b0010);
        drive_frame(0, 7, 1'b1, -1, -1);
        wait_drain("runt63");

        // Giant, then a back-to-back good frame
        make_payload(1600, 11);
        expect_frame(0, 1514, 3, 11'd1514, 4'b0100);
        drive_frame(0, 7, 1'b1, -1, -1);
        make_payload(60, 13); append_fcs();
        expect_frame(0, 60, 2, 11'd60, 4'b0000);
        drive_frame(0, 7, 1'b1, -1, -1);
        wait_drain("giant");

        // er on payload byte 20
        make_payload(60, 15); append_fcs();
        expect_frame(0, 60, 3, 11'd60, 4'b0001);
        drive_frame(0, 7, 1'b1, 20, -1);
        wait_drain("rx_er");

        // Bad preamble 0x55,0x57: nothing out; the next frame commits
        make_payload(20, 17);
        pay[0] = 8'h57;
        for (int i = 1; i < 6; i++) pay[i] = 8'h55;
        pay[6] = 8'hD5;
        drive_frame(0, 1, 1'b0, -1, -1);
        make_payload(60, 19); append_fcs();
        expect_frame(0, 60, 2, 11'd60, 4'b0000);
        drive_frame(0, 7, 1'b1, -1, -1);
        wait_drain("bad_preamble");

        // Preamble length: 16 rejected, 15 accepted
        make_payload(60, 21); append_fcs();
        drive_frame(0, 16, 1'b1, -1, -1);
        expect_frame(0, 60, 2, 11'd60, 4'b0000);
        drive_frame(0, 15, 1'b1, -1, -1);
        wait_drain("preamble_len");

        // Very short frames on the non-checking instance
        make_payload(3, 23);
        expect_frame(1, 0, 3, 11'd0, 4'b0010);
        drive_frame(1, 7, 1'b1, -1, -1);
        make_payload(4, 25);
        expect_frame(1, 0, 3, 11'd0, 4'b0010);
        drive_frame(1, 7, 1'b1, -1, -1);
        make_payload(5, 27);
        expect_frame(1, 1, 3, 11'd1, 4'b0010);
        drive_frame(1, 7, 1'b1, -1, -1);
        wait_drain("short");

        // 100M: one sampled cycle in ten, zero-FCS frame
        slow = 1'b1; timing_chk = 1'b0;
        make_payload(110, 3); append_zero_fcs();
        expect_frame(1, 110, 2, 11'd110, 4'b0000);
        drive_frame(1, 8, 1'b1, -1, -1);
        wait_drain("slow");
        slow = 1'b0; timing_chk = 1'b1;

        // Reset on payload byte 50, then a good frame
        make_payload(60, 29); append_fcs();
        expect_frame(0, 60, 2, 11'd60, 4'b0000);
        drive_frame(0, 7, 1'b1, -1, 50);
        make_payload(60, 31); append_fcs();
        expect_frame(0, 60, 2, 11'd60, 4'b0000);
        drive_frame(0, 7, 1'b1, -1, -1);
        wait_drain("reset_mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_rx_frame_parser.md
# gmii_rx_frame_parser

Receive-side framing stage that consumes a GMII receive bus (from a PHY or a bench-side traffic generator) in the `clk_mac` domain. It locates preamble/SFD, strips them, and withholds the 4-byte FCS. It forwards payload bytes as a simple valid-qualified stream and ends every frame with a single commit or drop pulse, giving byte count and drop reason. It feeds the MAC-domain rx FIFO / CDC stage.

## Interface
- `MAX_FRAME_LEN`, 1518: max frame length in bytes after SFD, FCS included.
- `MIN_FRAME_LEN`, 64: min frame length in bytes after SFD, FCS included.
- `CHECK_CRC`, 1: 1 = FCS mismatch causes drop. 0 = FCS ignored, for generators that send a zeroed FCS.
- `clk_mac`  in  1  MAC clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `gmii_rx_bus`  in  GmiiBus  fields `dvalid`, `en`, `er`, `data[7:0]`. A cycle is sampled only when `dvalid`=1.
- `rx_frame_start`  out  1  one-cycle pulse when a frame is accepted.
- `rx_frame_data_valid`  out  1  payload byte present on `rx_frame_data`.
- `rx_frame_data`  out  8  payload byte; FCS never appears here.
- `rx_frame_commit`  out  1  one-cycle pulse: frame good.
- `rx_frame_drop`  out  1  one-cycle pulse: frame bad; discard it.
- `rx_frame_bytes`  out  11  payload bytes emitted (excludes FCS). Valid with commit/drop; held until next start.
- `rx_drop_reason`  out  4  bit0 er, bit1 runt, bit2 giant, bit3 crc. Valid with drop; held until next start.

## Operation
- States: IDLE, PREAMBLE, FRAME, DROP. Cycles with `dvalid`=0 change no state, counter, or CRC.
- IDLE:
  - `en`=1 and `data`=0x55 → PREAMBLE, preamble count=1.
  - `en`=1 with any other data → DROP.
- PREAMBLE:
  - 0x55 → count+1. More than 15 0x55 bytes → DROP.
  - 0xD5 → FRAME; pulse `rx_frame_start` next cycle; CRC reg=0xFFFFFFFF; byte count=0; flags cleared.
  - `en`=0 → IDLE silently.
  - `er`=1 or any other byte → DROP silently; no start pulse.
- FRAME, each sampled byte with `en`=1:
  - Shifted into a 4-byte holdback pipe; byte count incremented.
  - CRC updated: reflected poly 0xEDB88320, LSB first.
  - `er`=1 sets the er flag.
  - Byte i is emitted once byte i+4 has been sampled.
- FRAME end (`en`=0 sampled):
  - Pipe contents (the FCS) discarded.
  - Runt flag if count < `MIN_FRAME_LEN`.
  - crc flag if `CHECK_CRC` and CRC reg ≠ 0xDEBB20E3 (residue, no final inversion).
  - Next cycle: commit if no flag set, else drop. → IDLE.
- Giant: sampling byte number `MAX_FRAME_LEN`+1 emits nothing further, pulses drop next cycle with reason=4'b0100, → DROP. No commit for that frame.
- DROP: wait for sampled `en`=0 → IDLE. No outputs.
- `rx_frame_bytes` = max(count−4, 0); saturates at 2047.
- Frames of ≤4 bytes after SFD: start pulse, zero data beats, drop (runt), bytes=0.
- Every start pulse is followed by exactly one commit or drop, except when reset intervenes.

## Timing
- Reset values: all outputs 0, `rx_drop_reason`=0, `rx_frame_bytes`=0, state IDLE, pipe empty.
- Reset mid-frame: outputs 0 on the next cycle; no commit/drop for the aborted frame. The IDLE→DROP rule discards the tail.
- Start pulse is registered: the cycle after SFD is sampled.
- Data latency at gigabit (`dvalid` always 1): byte i is output in the cycle after byte i+4 is sampled.
  - First data beat comes 5 cycles after the start pulse.
- Last payload beat is the cycle after the last FCS byte is sampled. Commit/drop follows 1 cycle later, i.e. the cycle after `en`=0 is sampled.
- `rx_frame_data_valid` asserts only in cycles following a sampled (`dvalid`=1) byte. It never asserts in the same cycle as commit/drop.
- `en` falling and `er` in the same sample: `er` ignored (`en`=0 ends the frame).
- No backpressure: consumer must accept every beat.

## Test plan
- Zero-FCS frame: 8×0x55, 0xD5, 110 payload bytes, 4×0x00 FCS; `CHECK_CRC`=0.
  → start; 110 beats matching payload in order; commit 1 cycle after last beat; `rx_frame_bytes`=110.
- CRC check, `CHECK_CRC`=1: 7×0x55, 0xD5, 60 payload bytes + correct FCS → commit, bytes=60.
  - Same frame with payload byte 10 bit0 flipped → drop, reason=4'b1000, bytes=60.
- Length limits:
  - 36 payload + valid FCS (40 total) → 36 beats, drop, reason=4'b0010.
  - 1600-byte frame, `MAX_FRAME_LEN`=1518 → 1514 beats, drop with reason=4'b0100, no commit. Next back-to-back frame commits normally.
- Errors:
  - `er`=1 on payload byte 20 → drop at end, reason=4'b0001.
  - Preamble 0x55,0x57 → no start, no outputs; next valid frame commits.
- Clock-enable and reset: `dvalid`=1 one cycle in ten (100M) with test 1 stimulus → identical beats, one per enabled sample; commit bytes=110. Assert `rst` on payload byte 50 → all outputs 0 the next cycle; no commit/drop; next frame commits.
